// File: rtl/cd_param.sv
// Parametrised single-cycle CPU datapath with a register file, an ALU with z/c flags,
// a hardware return-address stack for call/ret, and a global enable for stalling.
module cd_param #(
  parameter int W   = 16,
  parameter int PCW = 10,
  parameter int SD  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [31:0]    instruccion,
  output logic [PCW-1:0] pc_out,
  input  logic [1:0]     s_pc,
  input  logic           s_mux_alu,
  input  logic           s_mux_datos,
  input  logic           we3,
  input  logic           wez,
  input  logic           wec,
  input  logic [2:0]     op_alu,
  input  logic [W-1:0]   Datos,
  output logic [15:0]    Direcciones,
  output logic [W-1:0]   dout,
  output logic           z,
  output logic           c,
  output logic [5:0]     opcode,
  output logic           ovf,
  output logic           unf
);

  localparam int SPW = $clog2(SD + 1);
  localparam int AW  = $clog2(SD);

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_JMP  = 2'b01,
    PC_CALL = 2'b10,
    PC_RET  = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    ALU_A    = 3'b000,
    ALU_NOTA = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_NEGA = 3'b110,
    ALU_NEGB = 3'b111
  } alu_op_e;

  // Instruction fields
  logic [3:0]     ra1, ra2, wa;
  logic [W-1:0]   imm;
  logic [PCW-1:0] target;

  assign ra1         = instruccion[25:22];
  assign ra2         = instruccion[21:18];
  assign wa          = instruccion[17:14];
  assign imm         = W'(instruccion[15:0]);
  assign target      = instruccion[PCW-1:0];
  assign opcode      = instruccion[31:26];
  assign Direcciones = instruccion[15:0];

  // State
  logic [W-1:0]   rf_q [16];
  logic [PCW-1:0] stack_q [SD];
  logic [PCW-1:0] pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           z_q, z_d, c_q, c_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;

  assign pc_out = pc_q;
  assign z      = z_q;
  assign c      = c_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

  // Register file reads: R0 is hard-wired to zero, no write bypass.
  logic [W-1:0] rd1, rd2;
  assign rd1  = (ra1 == 4'd0) ? '0 : rf_q[ra1];
  assign rd2  = (ra2 == 4'd0) ? '0 : rf_q[ra2];
  assign dout = rd2;

  // ALU
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic         alu_c;
  logic [W:0]   sum_ext, diff_ext;

  assign alu_a    = s_mux_alu ? imm : rd1;
  assign alu_b    = rd2;
  assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b};

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    unique case (alu_op_e'(op_alu))
      ALU_A:    alu_r = alu_a;
      ALU_NOTA: alu_r = ~alu_a;
      ALU_ADD: begin
        alu_r = sum_ext[W-1:0];
        alu_c = sum_ext[W];
      end
      ALU_SUB: begin
        alu_r = diff_ext[W-1:0];
        alu_c = diff_ext[W];
      end
      ALU_AND:  alu_r = alu_a & alu_b;
      ALU_OR:   alu_r = alu_a | alu_b;
      ALU_NEGA: alu_r = '0 - alu_a;
      ALU_NEGB: alu_r = '0 - alu_b;
    endcase
  end

  logic [W-1:0] wb_data;
  assign wb_data = s_mux_datos ? Datos : alu_r;

  // Return-address stack control
  logic           stk_full, stk_empty, push_en;
  logic [PCW-1:0] pc_inc;
  logic [AW-1:0]  push_idx, pop_idx;

  assign pc_inc    = pc_q + PCW'(1);
  assign stk_full  = (sp_q == SPW'(SD));
  assign stk_empty = (sp_q == '0);
  assign push_idx  = AW'(sp_q);
  assign pop_idx   = AW'(sp_q - SPW'(1));

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    z_d     = z_q;
    c_d     = c_q;
    push_en = 1'b0;
    if (en) begin
      if (wez) z_d = (alu_r == '0);
      if (wec) c_d = alu_c;
      unique case (pc_sel_e'(s_pc))
        PC_INC: pc_d = pc_inc;
        PC_JMP: pc_d = target;
        PC_CALL: begin
          pc_d = target;
          if (stk_full) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
          end
        end
        PC_RET: begin
          if (stk_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - SPW'(1);
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      z_q   <= z_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: the register file and stack are cleared by reset, so they are flops rather than RAM macros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (en && we3 && (wa != 4'd0)) begin
      rf_q[wa] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SD; i++) stack_q[i] <= '0;
    end else if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_cd_param.sv
// Self-checking bench for cd_param: directed scenarios plus random traffic compared
// against a queue-based behavioural model of the datapath.
module tb_cd_param;

  localparam int W   = 16;
  localparam int PCW = 10;
  localparam int SD  = 8;
  localparam int PCM = 1 << PCW;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [31:0]    instruccion;
  logic [PCW-1:0] pc_out;
  logic [1:0]     s_pc;
  logic           s_mux_alu, s_mux_datos, we3, wez, wec;
  logic [2:0]     op_alu;
  logic [W-1:0]   Datos;
  logic [15:0]    Direcciones;
  logic [W-1:0]   dout;
  logic           z, c, ovf, unf;
  logic [5:0]     opcode;

  cd_param #(.W(W), .PCW(PCW), .SD(SD)) dut (
    .clk(clk), .reset(reset), .en(en), .instruccion(instruccion), .pc_out(pc_out),
    .s_pc(s_pc), .s_mux_alu(s_mux_alu), .s_mux_datos(s_mux_datos), .we3(we3),
    .wez(wez), .wec(wec), .op_alu(op_alu), .Datos(Datos), .Direcciones(Direcciones),
    .dout(dout), .z(z), .c(c), .opcode(opcode), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model
  int unsigned m_rf [16];
  int          m_pc;
  int          m_stack [$];
  logic        m_z, m_c, m_ovf, m_unf;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    m_pc = 0;
    m_stack.delete();
    m_z = 0; m_c = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [5:0] opc, input logic [3:0] r1,
                                      input logic [3:0] r2, input logic [3:0] w,
                                      input logic [13:0] lo);
    return {opc, r1, r2, w, lo};
  endfunction

  task automatic step(input logic [31:0] iw, input logic [1:0] spc, input logic [2:0] op,
                      input logic smalu, input logic smdat, input logic w3, input logic wz,
                      input logic wc, input logic e, input logic [15:0] dat);
    int unsigned a, b, r, cc, wb;
    int ra1, ra2, wa, tgt;
    instruccion = iw; s_pc = spc; op_alu = op; s_mux_alu = smalu; s_mux_datos = smdat;
    we3 = w3; wez = wz; wec = wc; en = e; Datos = dat;
    #1;
    ra1 = int'(iw[25:22]); ra2 = int'(iw[21:18]); wa = int'(iw[17:14]); tgt = int'(iw[9:0]);
    check("dout", 32'(dout), m_rf[ra2]);
    check("direcciones", 32'(Direcciones), 32'(iw[15:0]));
    check("opcode", 32'(opcode), 32'(iw[31:26]));
    a = smalu ? int'(iw[15:0]) : m_rf[ra1];
    b = m_rf[ra2];
    case (op)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: r = a + b;
      3'd3: r = a - b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = 0 - a;
      default: r = 0 - b;
    endcase
    r  = r & 32'hFFFF;
    cc = (op == 3'd2) ? (((a + b) >> 16) & 1) : (op == 3'd3) ? ((a < b) ? 1 : 0) : 0;
    wb = smdat ? int'(dat) : r;
    @(posedge clk);
    if (e) begin
      if (w3 && wa != 0) m_rf[wa] = wb;
      if (wz) m_z = (r == 0);
      if (wc) m_c = cc[0];
      case (spc)
        2'd0: m_pc = (m_pc + 1) % PCM;
        2'd1: m_pc = tgt;
        2'd2: begin
          if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) % PCM);
          else m_ovf = 1;
          m_pc = tgt;
        end
        default: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc  = (m_pc + 1) % PCM;
            m_unf = 1;
          end
        end
      endcase
    end
    #1;
    check("pc", 32'(pc_out), 32'(m_pc));
    check("z", 32'(z), 32'(m_z));
    check("c", 32'(c), 32'(m_c));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("unf", 32'(unf), 32'(m_unf));
  endtask

  task automatic nop();
    step(ins(6'd0, 4'd0, 4'd0, 4'd0, 14'd0), 2'b00, 3'd0, 0, 0, 0, 0, 0, 1, 16'd0);
  endtask

  task automatic readreg(input int k);
    step(ins(6'd0, 4'd0, 4'(k), 4'd0, 14'd0), 2'b00, 3'd0, 0, 0, 0, 0, 0, 0, 16'd0);
  endtask

  task automatic jump(input int t);
    step(ins(6'd1, 4'd0, 4'd0, 4'd0, 14'(t)), 2'b01, 3'd0, 0, 0, 0, 0, 0, 1, 16'd0);
  endtask

  task automatic call(input int t);
    step(ins(6'd2, 4'd0, 4'd0, 4'd0, 14'(t)), 2'b10, 3'd0, 0, 0, 0, 0, 0, 1, 16'd0);
  endtask

  task automatic ret();
    step(ins(6'd3, 4'd0, 4'd0, 4'd0, 14'd0), 2'b11, 3'd0, 0, 0, 0, 0, 0, 1, 16'd0);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; instruccion = '0; s_pc = '0; s_mux_alu = 0; s_mux_datos = 0;
    we3 = 0; wez = 0; wec = 0; op_alu = '0; Datos = '0;
    model_reset();
    #12;
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_flags", {28'd0, z, c, ovf, unf}, 32'd0);
    reset = 1'b1;

    // All registers read zero after reset; en=0 keeps the PC frozen meanwhile.
    for (int k = 0; k < 16; k++) readreg(k);
    for (int i = 0; i < 3; i++) begin
      nop();
      check("rst_trace", 32'(pc_out), 32'(i + 1));
    end

    // ALU and flags
    step(ins(6'd4, 4'd0, 4'd0, 4'd1, 14'd0), 2'b00, 3'b001, 0, 0, 1, 0, 0, 1, 16'd0);
    step(ins(6'd5, 4'd1, 4'd1, 4'd2, 14'd0), 2'b00, 3'b010, 0, 0, 1, 1, 1, 1, 16'd0);
    check("add_c", 32'(c), 32'd1);
    check("add_z", 32'(z), 32'd0);
    readreg(2);
    check("r2_sum", 32'(dout), 32'hFFFE);
    step(ins(6'd6, 4'd1, 4'd1, 4'd0, 14'd0), 2'b00, 3'b011, 0, 0, 0, 1, 1, 1, 16'd0);
    check("sub_z", 32'(z), 32'd1);
    check("sub_c", 32'(c), 32'd0);
    step(ins(6'd7, 4'd0, 4'd0, 4'd0, 14'd0), 2'b00, 3'b001, 0, 0, 1, 0, 0, 1, 16'd0);
    readreg(0);
    check("r0_zero", 32'(dout), 32'd0);
    step(ins(6'd8, 4'd0, 4'd0, 4'd4, 14'd0), 2'b00, 3'b000, 0, 1, 1, 0, 0, 1, 16'hA5C3);
    readreg(4);
    check("r4_datos", 32'(dout), 32'hA5C3);

    // Nested call/ret
    jump(5);
    check("nest_start", 32'(pc_out), 32'h5);
    call(32'h20); check("nest_call1", 32'(pc_out), 32'h20);
    call(32'h40); check("nest_call2", 32'(pc_out), 32'h40);
    ret();        check("nest_ret1", 32'(pc_out), 32'h21);
    ret();        check("nest_ret2", 32'(pc_out), 32'h6);

    // Wrapped return address and PC wrap
    jump(PCM - 1);
    call(32'h10);
    ret();
    check("wrap_ret", 32'(pc_out), 32'h0);
    jump(PCM - 1);
    nop();
    check("wrap_inc", 32'(pc_out), 32'h0);

    // Overflow and underflow
    for (int i = 0; i < SD + 1; i++) begin
      call(32'h100 + i);
      if (i == SD - 1) check("ovf_before", 32'(ovf), 32'd0);
    end
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_jump", 32'(pc_out), 32'h108);
    for (int i = 0; i < SD + 1; i++) begin
      ret();
      if (i == 0) check("pop_first", 32'(pc_out), 32'h107);
      if (i == SD - 1) begin
        check("pop_last", 32'(pc_out), 32'h1);
        check("unf_before", 32'(unf), 32'd0);
      end
    end
    check("unf_set", 32'(unf), 32'd1);
    check("unf_pc", 32'(pc_out), 32'h2);

    // Stall: call + write + flag write held off by en=0
    for (int i = 0; i < 4; i++)
      step(ins(6'd9, 4'd0, 4'd0, 4'd3, 14'h55), 2'b10, 3'b001, 0, 0, 1, 1, 1, 0, 16'd0);
    check("stall_pc", 32'(pc_out), 32'h2);
    step(ins(6'd9, 4'd0, 4'd0, 4'd3, 14'h55), 2'b10, 3'b001, 0, 0, 1, 1, 1, 1, 16'd0);
    check("stall_call", 32'(pc_out), 32'h55);
    readreg(3);
    check("stall_r3", 32'(dout), 32'hFFFF);
    ret();
    check("stall_ret", 32'(pc_out), 32'h3);

    // Random traffic
    for (int n = 0; n < 400; n++)
      step($urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) != 0), 16'($urandom));

    // Asynchronous reset with three entries on the stack
    for (int i = 0; i < SD; i++) ret();
    call(32'h30); call(32'h31); call(32'h32);
    #3;
    reset = 1'b0;
    #1;
    check("arst_pc", 32'(pc_out), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_unf", 32'(unf), 32'd0);
    model_reset();
    #2;
    reset = 1'b1;
    ret();
    check("arst_sp_empty", 32'(unf), 32'd1);
    check("arst_ret_pc", 32'(pc_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
